// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-port data memory.
package dmem_pkg;

  typedef enum logic {CLEAR, RUN} state_t;

  localparam int DEFAULT_DEPTH = 512;

  // Clear-counter width, $clog2(depth), held at a minimum of one bit.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_write_resolve.sv
// Combinational write arbitration: per-port range check, winning writer
// selection (highest port index) and same-address forward data.
module dmem_write_resolve
  import dmem_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic [NPORTS*ADDR_W-1:0] addr,
  input  logic [NPORTS*DATA_W-1:0] wdata,
  input  logic [NPORTS-1:0]        wr_en,
  output logic [NPORTS-1:0]        in_range,
  output logic [NPORTS-1:0]        wr_win,
  output logic [NPORTS-1:0]        fwd_hit,
  output logic [NPORTS*DATA_W-1:0] fwd_data
);

  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  always_comb begin
    in_range = '0;
    for (int p = 0; p < NPORTS; p++) begin
      in_range[p] = ({1'b0, addr[p*ADDR_W +: ADDR_W]} < DEPTH_A);
    end
  end

  // Scanning writers in ascending order leaves the highest matching port's
  // data in fwd_data, which is the same writer that keeps its wr_win bit.
  always_comb begin
    wr_win   = '0;
    fwd_hit  = '0;
    fwd_data = '0;
    for (int p = 0; p < NPORTS; p++) begin
      wr_win[p] = wr_en[p] & in_range[p];
      for (int q = 0; q < NPORTS; q++) begin
        if (wr_en[q] && in_range[q] &&
            (addr[q*ADDR_W +: ADDR_W] == addr[p*ADDR_W +: ADDR_W])) begin
          fwd_hit[p]                  = 1'b1;
          fwd_data[p*DATA_W +: DATA_W] = wdata[q*DATA_W +: DATA_W];
          if (q > p) wr_win[p] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/multiport_data_memory.sv
// N-port data memory with registered reads, fixed-priority write
// resolution, optional write-to-read bypass and a post-reset clear sweep.
//   state | meaning
//   CLEAR | sweeping zeros into the array (or waiting one edge); requests ignored
//   RUN   | ready; reads and writes accepted on every port
module multiport_data_memory
  import dmem_pkg::*;
#(
  parameter int NPORTS     = 2,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int FWD        = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NPORTS*ADDR_W-1:0] addr,
  input  logic [NPORTS*DATA_W-1:0] wdata,
  input  logic [NPORTS-1:0]        wr_en,
  input  logic [NPORTS-1:0]        rd_en,
  output logic [NPORTS*DATA_W-1:0] rdata,
  output logic [NPORTS-1:0]        rvalid,
  output logic [NPORTS-1:0]        oob_err,
  output logic                     ready
);

  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [DATA_W-1:0]        mem [DEPTH];
  logic                     run;
  logic [NPORTS-1:0]        wr_act;
  logic [NPORTS-1:0]        in_range;
  logic [NPORTS-1:0]        wr_win;
  logic [NPORTS-1:0]        fwd_hit;
  logic [NPORTS*DATA_W-1:0] fwd_data;

  assign run    = (state == RUN);
  assign wr_act = wr_en & {NPORTS{run}};

  dmem_write_resolve #(
    .NPORTS (NPORTS),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_resolve (
    .addr     (addr),
    .wdata    (wdata),
    .wr_en    (wr_act),
    .in_range (in_range),
    .wr_win   (wr_win),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
  );

  // The array has no reset; reset forces CLEAR, so no RUN write can land on
  // the reset edge and the sweep restarts from word 0.
  always_ff @(posedge clock) begin
    if (!run) begin
      if (INIT_CLEAR != 0) mem[cnt] <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (wr_win[p]) mem[addr[p*ADDR_W +: CW]] <= wdata[p*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      cnt     <= '0;
      ready   <= 1'b0;
      rdata   <= '0;
      rvalid  <= '0;
      oob_err <= '0;
    end else begin
      rvalid  <= '0;
      oob_err <= '0;
      case (state)
        CLEAR: begin
          if ((INIT_CLEAR == 0) || (cnt == LAST)) begin
            state <= RUN;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          for (int p = 0; p < NPORTS; p++) begin
            if ((rd_en[p] || wr_en[p]) && !in_range[p]) oob_err[p] <= 1'b1;
            if (rd_en[p]) begin
              rvalid[p] <= 1'b1;
              if (!in_range[p]) begin
                rdata[p*DATA_W +: DATA_W] <= '0;
              end else if ((FWD != 0) && fwd_hit[p]) begin
                rdata[p*DATA_W +: DATA_W] <= fwd_data[p*DATA_W +: DATA_W];
              end else begin
                rdata[p*DATA_W +: DATA_W] <= mem[addr[p*ADDR_W +: CW]];
              end
            end
          end
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiport_data_memory.sv
// Bench for multiport_data_memory: a FWD=1/INIT_CLEAR=1 instance and a
// FWD=0/INIT_CLEAR=0 instance, checked against hand-derived expectations.
module tb_multiport_data_memory;

  localparam int DEPTH = 512;

  typedef struct {
    logic [1:0]  wr;
    logic [1:0]  rd;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  rv;
    logic [1:0]  oob;
    logic [15:0] r0;
    logic [15:0] r1;
  } vec_t;

  typedef struct {
    bit          b;
    logic [1:0]  rv;
    logic [1:0]  oob;
    logic [31:0] rd;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [31:0] addr, wdata, addr_b, wdata_b;
  logic [1:0]  wr_en, rd_en, wr_en_b, rd_en_b;
  logic [31:0] rdata, rdata_b;
  logic [1:0]  rvalid, oob_err, rvalid_b, oob_err_b;
  logic        ready, ready_b;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  vec_t tbl[18];

  multiport_data_memory #(
    .NPORTS(2), .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .FWD(1), .INIT_CLEAR(1)
  ) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .wr_en(wr_en),
    .rd_en(rd_en), .rdata(rdata), .rvalid(rvalid), .oob_err(oob_err), .ready(ready)
  );

  multiport_data_memory #(
    .NPORTS(2), .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .FWD(0), .INIT_CLEAR(0)
  ) dut_b (
    .clock(clock), .reset(reset), .addr(addr_b), .wdata(wdata_b), .wr_en(wr_en_b),
    .rd_en(rd_en_b), .rdata(rdata_b), .rvalid(rvalid_b), .oob_err(oob_err_b), .ready(ready_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    addr = '0; wdata = '0; wr_en = '0; rd_en = '0;
    addr_b = '0; wdata_b = '0; wr_en_b = '0; rd_en_b = '0;
  endtask

  task automatic step(input bit b, input vec_t v, input string nm);
    exp_t e;
    if (b) begin
      addr_b = {v.a1, v.a0}; wdata_b = {v.d1, v.d0}; wr_en_b = v.wr; rd_en_b = v.rd;
    end else begin
      addr = {v.a1, v.a0}; wdata = {v.d1, v.d0}; wr_en = v.wr; rd_en = v.rd;
    end
    sb.push_back('{b, v.rv, v.oob, {v.r1, v.r0}});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    if (e.b) begin
      chk({nm, "_rvalid"}, 32'(rvalid_b), 32'(e.rv));
      chk({nm, "_oob"}, 32'(oob_err_b), 32'(e.oob));
      chk({nm, "_rdata"}, rdata_b, e.rd);
    end else begin
      chk({nm, "_rvalid"}, 32'(rvalid), 32'(e.rv));
      chk({nm, "_oob"}, 32'(oob_err), 32'(e.oob));
      chk({nm, "_rdata"}, rdata, e.rd);
    end
    idle_inputs();
  endtask

  // Walks exactly DEPTH edges after reset release; optionally fires requests
  // mid-sweep that must be ignored (including a write of 0xFFFF to word 3).
  task automatic sweep(input string nm, input bit poke);
    bit seen;
    seen = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      if (poke && i >= 100 && i < 150) begin
        addr = {16'd600, 16'd3}; wdata = {16'hEEEE, 16'hFFFF};
        wr_en = 2'b11; rd_en = 2'b11;
      end else begin
        idle_inputs();
      end
      @(posedge clock);
      #1;
      if (rvalid != 2'b00 || oob_err != 2'b00) seen = 1'b1;
      if (i == DEPTH - 1) chk({nm, "_ready_pre"}, 32'(ready), 32'd0);
      if (i == DEPTH) chk({nm, "_ready"}, 32'(ready), 32'd1);
    end
    idle_inputs();
    if (poke) chk({nm, "_ignored"}, 32'(seen), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{2'b11, 2'b00, 16'd5,   16'd5,   16'h1111, 16'h2222, 2'b00, 2'b00, 16'h0000, 16'h0000};
    tbl[1]  = '{2'b00, 2'b11, 16'd5,   16'd3,   16'h0000, 16'h0000, 2'b11, 2'b00, 16'h2222, 16'h0000};
    tbl[2]  = '{2'b10, 2'b01, 16'd7,   16'd7,   16'h0000, 16'hABCD, 2'b01, 2'b00, 16'hABCD, 16'h0000};
    tbl[3]  = '{2'b00, 2'b11, 16'd7,   16'd5,   16'h0000, 16'h0000, 2'b11, 2'b00, 16'hABCD, 16'h2222};
    tbl[4]  = '{2'b00, 2'b01, 16'd600, 16'd0,   16'h0000, 16'h0000, 2'b01, 2'b01, 16'h0000, 16'h2222};
    tbl[5]  = '{2'b01, 2'b00, 16'd600, 16'd0,   16'hBEEF, 16'h0000, 2'b00, 2'b01, 16'h0000, 16'h2222};
    tbl[6]  = '{2'b00, 2'b11, 16'd88,  16'd511, 16'h0000, 16'h0000, 2'b11, 2'b00, 16'h0000, 16'h0000};
    tbl[7]  = '{2'b10, 2'b01, 16'd0,   16'd0,   16'h0000, 16'h0F0F, 2'b01, 2'b00, 16'h0F0F, 16'h0000};
    tbl[8]  = '{2'b01, 2'b10, 16'd9,   16'd9,   16'h1357, 16'h0000, 2'b10, 2'b00, 16'h0F0F, 16'h1357};
    tbl[9]  = '{2'b11, 2'b01, 16'd10,  16'd10,  16'hAAAA, 16'hBBBB, 2'b01, 2'b00, 16'hBBBB, 16'h1357};
    tbl[10] = '{2'b00, 2'b11, 16'd10,  16'd9,   16'h0000, 16'h0000, 2'b11, 2'b00, 16'hBBBB, 16'h1357};
    tbl[11] = '{2'b00, 2'b10, 16'd0,   16'hFFFF, 16'h0000, 16'h0000, 2'b10, 2'b10, 16'hBBBB, 16'h0000};
    tbl[12] = '{2'b10, 2'b00, 16'd0,   16'd511, 16'h0000, 16'h5A5A, 2'b00, 2'b00, 16'hBBBB, 16'h0000};
    tbl[13] = '{2'b00, 2'b11, 16'd512, 16'd511, 16'h0000, 16'h0000, 2'b11, 2'b01, 16'h0000, 16'h5A5A};
    tbl[14] = '{2'b01, 2'b01, 16'd20,  16'd0,   16'h7777, 16'h0000, 2'b01, 2'b00, 16'h7777, 16'h5A5A};
    tbl[15] = '{2'b00, 2'b00, 16'd0,   16'd0,   16'h0000, 16'h0000, 2'b00, 2'b00, 16'h7777, 16'h5A5A};
    tbl[16] = '{2'b00, 2'b11, 16'd0,   16'd0,   16'h0000, 16'h0000, 2'b11, 2'b00, 16'h0F0F, 16'h0F0F};
    tbl[17] = '{2'b00, 2'b11, 16'd5,   16'd20,  16'h0000, 16'h0000, 2'b11, 2'b00, 16'h2222, 16'h7777};

    reset = 1'b0;
    idle_inputs();
    #12;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_oob", 32'(oob_err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready_b", 32'(ready_b), 32'd0);

    // First release: no-clear instance is ready after one edge.
    @(negedge clock);
    reset = 1'b1;
    #2;
    chk("b_ready_pre", 32'(ready_b), 32'd0);
    @(posedge clock);
    #1;
    chk("b_ready_first_edge", 32'(ready_b), 32'd1);

    // Reset in the middle of the sweep at count 200.
    repeat (199) @(posedge clock);
    #1;
    chk("midclear_ready", 32'(ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("midclear_rst_ready", 32'(ready), 32'd0);
    chk("midclear_rst_rvalid", 32'(rvalid), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    sweep("sweep1", 1'b1);

    step(1'b0, '{2'b00, 2'b01, 16'd3, 16'd0, 16'h0, 16'h0, 2'b01, 2'b00, 16'h0000, 16'h0000}, "read3_after_clear");

    for (int i = 0; i < 18; i++) step(1'b0, tbl[i], $sformatf("vec%0d", i));

    // Read-old instance.
    step(1'b1, '{2'b01, 2'b00, 16'd7, 16'd0, 16'h1234, 16'h0, 2'b00, 2'b00, 16'h0000, 16'h0000}, "b_wr7");
    step(1'b1, '{2'b10, 2'b01, 16'd7, 16'd7, 16'h0, 16'hABCD, 2'b01, 2'b00, 16'h1234, 16'h0000}, "b_xport_old");
    step(1'b1, '{2'b00, 2'b01, 16'd7, 16'd0, 16'h0, 16'h0, 2'b01, 2'b00, 16'hABCD, 16'h0000}, "b_rd7_new");
    step(1'b1, '{2'b01, 2'b00, 16'd8, 16'd0, 16'h1111, 16'h0, 2'b00, 2'b00, 16'hABCD, 16'h0000}, "b_wr8");
    step(1'b1, '{2'b01, 2'b01, 16'd8, 16'd0, 16'h2222, 16'h0, 2'b01, 2'b00, 16'h1111, 16'h0000}, "b_sameport_old");
    step(1'b1, '{2'b00, 2'b11, 16'd8, 16'd7, 16'h0, 16'h0, 2'b11, 2'b00, 16'h2222, 16'hABCD}, "b_rd_both");
    step(1'b1, '{2'b00, 2'b10, 16'd0, 16'd512, 16'h0, 16'h0, 2'b10, 2'b10, 16'h2222, 16'h0000}, "b_oob");

    // Reset during RUN with a valid read on the outputs.
    step(1'b0, '{2'b00, 2'b01, 16'd20, 16'd0, 16'h0, 16'h0, 2'b01, 2'b00, 16'h7777, 16'h7777}, "pre_midrun");
    #2;
    reset = 1'b0;
    #1;
    chk("midrun_rdata", rdata, 32'd0);
    chk("midrun_rvalid", 32'(rvalid), 32'd0);
    chk("midrun_ready", 32'(ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    sweep("sweep2", 1'b0);
    step(1'b0, '{2'b00, 2'b11, 16'd5, 16'd20, 16'h0, 16'h0, 2'b11, 2'b00, 16'h0000, 16'h0000}, "after_sweep2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multiport_data_memory.md
# multiport_data_memory

Parametrised N-port data memory for the superscalar pipeline's memory stage, generalising the fixed two-port data memory. Every port can read and write each cycle. Reads are registered with a valid strobe, and write conflicts are resolved by fixed port priority. An optional same-cycle write-to-read bypass is provided. After reset, a clear state machine zeroes the array, because the asynchronous reset cannot clear the array directly.

## Interface
Parameters:
- NPORTS, 2: number of independent access ports (1..4)
- DATA_W, 16: word width
- ADDR_W, 16: address width per port
- DEPTH, 512: words stored; addresses 0..DEPTH-1 are valid
- FWD, 1: 1 = same-cycle write data bypasses to a same-address read; 0 = read-old
- INIT_CLEAR, 1: 1 = sweep array to zero after reset; 0 = skip the sweep

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- addr  in  NPORTS*ADDR_W  port p address at bits [p*ADDR_W +: ADDR_W]
- wdata  in  NPORTS*DATA_W  port p write data
- wr_en  in  NPORTS  port p write request
- rd_en  in  NPORTS  port p read request
- rdata  out  NPORTS*DATA_W  port p registered read data
- rvalid  out  NPORTS  port p read data valid, one-cycle pulse
- oob_err  out  NPORTS  port p access address ≥ DEPTH, one-cycle pulse
- ready  out  1  high when requests are accepted (state RUN)

## Operation
- FSM states: CLEAR, RUN.
- While reset is low: state = CLEAR, clear counter = 0, all outputs 0.
- On reset release with INIT_CLEAR=1:
  - CLEAR writes 0 to word[cnt] each cycle for DEPTH cycles.
  - After word DEPTH-1 is written, the FSM moves to RUN.
- On reset release with INIT_CLEAR=0: the FSM moves to RUN on the first clock edge.
- In CLEAR, rd_en and wr_en are ignored: no writes occur, and rvalid and oob_err stay 0.
- Requests in RUN are accepted only when ready=1; port requests are independent.
- Writes:
  - A write with wr_en[p]=1 and addr < DEPTH updates word[addr] at the edge.
  - If several ports write the same address, the highest-index port wins; the other writes are dropped.
- Reads:
  - A read with rd_en[p]=1 loads rdata[p] at the edge and asserts rvalid[p] for the next cycle.
  - With FWD=0, the read returns the contents before that edge's writes.
  - With FWD=1 and a same-cycle write to the same address, the read returns the winning write data.
  - Otherwise it returns the stored word.
- Out of range: addr ≥ DEPTH drops the write and returns read data 0.
  - oob_err[p] pulses in the cycle after the edge that accepted the access; for reads, this coincides with rvalid.
- rdata[p] holds its last value when no read is accepted; it never floats.
- Reset mid-operation: the FSM returns to CLEAR immediately, outputs go to 0, and the sweep restarts from word 0.
  - An in-flight write on the reset edge is lost.

## Timing
- Read latency is 1 cycle: request at edge k, data and rvalid valid in the cycle after edge k, until edge k+1.
- Write latency is 1 edge: a later read sees the new data from the next edge onward.
- With INIT_CLEAR=1, ready is high DEPTH cycles after the first post-reset edge.
- With INIT_CLEAR=0, ready is high 1 cycle after the first post-reset edge.
- Simultaneous read and write on one port to the same address follows the FWD rule.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package dmem_pkg: state enum {CLEAR, RUN}, and a localparam for counter width, $clog2(DEPTH).
- Sub-module dmem_write_resolve is combinational:
  - Per address match, it selects the winning writer (highest index).
  - It produces the per-port forward data and hit flag.
  - It is instantiated once and used by both the write path and the FWD path.
- Top level contains the FSM, clear counter, memory array and read registers.

## Test plan
- Reset, then INIT_CLEAR=1, DEPTH=512: ready rises 512 cycles after release; a read of address 3 returns 0x0000 with rvalid the next cycle.
- Port 0 and port 1 write 0x1111 and 0x2222 to address 5 in the same cycle; a later read returns 0x2222.
- FWD=1: port 1 writes 0xABCD to address 7 while port 0 reads address 7 → rdata0 = 0xABCD; the same test with FWD=0 → old value.
- Port 0 reads address 600 → rdata0 = 0, oob_err[0] = rvalid[0] = 1 for one cycle; a write to address 600 leaves the memory unchanged.
- Reset asserted mid-CLEAR (count 200) and mid-RUN: outputs are 0 immediately, and the sweep restarts and takes the full 512 cycles.
- Requests issued while ready=0 produce no rvalid and modify no words (verify 0x0000 after ready).
